// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // Starvation counter width; the counter saturates at its all-ones value.
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // PRIO0 favours the CPU port; FORCE1 hands the next slot to port 1.
  typedef enum logic {
    PRIO0  = 1'b0,
    FORCE1 = 1'b1
  } arb_state_t;

  // One requester's access bundle at the default memory geometry.
  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Counts consecutive cycles in which port 1 asked for the memory and lost.
// force_req_o flags the cycle whose loss would exhaust port 1's patience,
// so the arbiter can hand port 1 the following slot.
module dmem_starve_ctr
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic gnt_i,
  output logic force_req_o
);

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear whenever port 1 is served or stops asking, else count up and saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Register the count; the synchronous reset starts port 1 with a clean slate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Port 1 is one denial away from its limit while it is still requesting.
  always_comb begin
    force_req_o = req_i && (cnt_q == LIMIT_M1);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory. Port 0 (CPU)
// normally wins; a starvation counter occasionally forces a port-1 grant.
// Grants and memory controls are combinational; read data returns one
// cycle later through per-port registers.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W       = dmem_pkg::ADDR_W,
  parameter int DATA_W       = dmem_pkg::DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic              force_req;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  dmem_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req1),
    .gnt_i      (gnt1),
    .force_req_o(force_req)
  );

  // Pick the winner this cycle from the current priority state; nobody wins during reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      case (state_q)
        FORCE1: begin
          if (req1) begin
            gnt1 = 1'b1;
          end else if (req0) begin
            gnt0 = 1'b1;
          end
        end
        default: begin
          if (req0) begin
            gnt0 = 1'b1;
          end else if (req1) begin
            gnt1 = 1'b1;
          end
        end
      endcase
    end
  end

  // Route the granted port onto the memory bus; an idle bus is driven to zero.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt0) begin
      sel_we    = we0;
      sel_addr  = addr0;
      sel_wdata = wdata0;
    end else if (gnt1) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
    mem_read  = (gnt0 || gnt1) && !sel_we;
    mem_write = (gnt0 || gnt1) && sel_we;
    mem_addr  = sel_addr;
    mem_wdata = sel_wdata;
  end

  // Priority transitions: enter FORCE1 when port 1 just lost for the last allowed time, leave once it is served or gone.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIO0: begin
        if (force_req && gnt0) begin
          state_d = FORCE1;
        end
      end
      FORCE1: begin
        if (gnt1 || !req1) begin
          state_d = PRIO0;
        end
      end
      default: state_d = PRIO0;
    endcase
  end

  // Register the priority state and capture read data for whichever port was granted a read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= PRIO0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      rvalid0_q <= gnt0 && !we0;
      rvalid1_q <= gnt1 && !we1;
      if (gnt0 && !we0) begin
        rdata0_q <= mem_rdata;
      end
      if (gnt1 && !we1) begin
        rdata1_q <= mem_rdata;
      end
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single-port 256x8 data memory (combinational read, synchronous write).
- Port 0 is the CPU load/store stage; port 1 is a secondary master such as the DMA/block-copy engine or the debug loader.
- Issues at most one memory access per cycle and registers read data back to the winning requester.
- Fixed priority to port 0, with a starvation counter that forces a port-1 grant.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.
- STARVE_LIMIT, 4, consecutive denied cycles of port 1 before port 1 is forced to win (range 1..15).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- req0 / req1  input  1  access request, port 0 / 1.
- we0 / we1  input  1  1 = write, 0 = read.
- addr0 / addr1  input  ADDR_W  access address.
- wdata0 / wdata1  input  DATA_W  write data.
- gnt0 / gnt1  output  1  combinational grant, same cycle as request.
- rvalid0 / rvalid1  output  1  registered read-return strobe.
- rdata0 / rdata1  output  DATA_W  registered read data, valid when rvalidN=1.
- mem_read  output  1  to memory memRead.
- mem_write  output  1  to memory memWrite.
- mem_addr  output  ADDR_W  to memory address.
- mem_wdata  output  DATA_W  to memory writeData.
- mem_rdata  input  DATA_W  from memory readData.

Behaviour:
- **Reset.** Clock is clk; reset rst_n is synchronous, active-low. While rst_n=0 at a posedge:
  - state<=PRIO0, starve_cnt<=0;
  - rvalid0/1<=0, rdata0/1<=0.
  - gnt0/1, mem_read and mem_write are forced 0 combinationally while rst_n=0.
- **States.**
  - PRIO0: if req0, grant 0; else if req1, grant 1.
  - FORCE1: if req1, grant 1; else if req0, grant 0.
- **Transitions.**
  - PRIO0 to FORCE1 when starve_cnt==STARVE_LIMIT-1 and this cycle has req1 & gnt0.
  - FORCE1 to PRIO0 on any cycle where gnt1=1, or where req1=0.
- **starve_cnt (4 bits).**
  - Increments when req1 & !gnt1.
  - Clears on gnt1 or !req1.
  - Saturates at 15.
- **Mux.**
  - mem_addr / mem_wdata come from the granted port; 0 when no grant.
  - mem_read = grant & !we; mem_write = grant & we.
  - At most one of mem_read / mem_write is high per cycle.
- **Read latency.** A granted read in cycle N gives rvalidN=1 with rdataN=mem_rdata (sampled at posedge N) in cycle N+1 for exactly one cycle.
  - rdataN holds its value afterwards.
  - mem_rdata is never sampled when mem_read=0, because it is high-Z then.
- **Writes.** The memory commits at posedge N. No rvalid is produced.
  - A read of the same address by either port in cycle N+1 returns the new data.
- **Handshake.** The requester holds req/we/addr/wdata stable until it sees gnt. A request accepted in cycle N may be followed by a new request in N+1 (back-to-back, full throughput).
- **Simultaneous requests.** Exactly one grant; the loser sees gnt=0 and retries. There is no internal request queue.
- **Idle.** No req gives no grant, mem_read=mem_write=0, and the state holds.
- **Reset mid-read.** A read granted in the cycle where rst_n is sampled 0 produces no rvalid.

Decomposition:
- Package dmem_pkg:
  - typedef arb_state_t {PRIO0, FORCE1};
  - constants ADDR_W, DATA_W;
  - typedef mem_req_t struct {req, we, addr, wdata}.
- One natural sub-module, dmem_starve_ctr: the saturating counter plus the limit compare, emitting force_req.
- The mux and read-return registers stay in the top level.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, then 1 with no req → all outputs 0, mem_read=mem_write=0, state PRIO0.
2. Single write/read on port 0: write addr 0x10, data 0xA5 (gnt0=1, mem_write=1); next cycle read 0x10 → cycle after, rvalid0=1, rdata0=0xA5 for one cycle.
3. Contention: req0 and req1 both held continuously as reads, STARVE_LIMIT=4 → grant pattern 0,0,0,0,1,0,0,0,0,1…; port 1 never waits more than 4 cycles.
4. Port 1 alone: req1 write addr 0xFF, data 0x3C; then port 0 reads 0xFF → gnt1 same cycle; rdata0=0x3C one cycle after the read grant; the wrap-top address is honoured.
5. Back-to-back alternating: port 0 reads 0x01/0x02 in cycles N and N+1; port 1 waits → rvalid0 in N+1 and N+2 with the correct data; starve_cnt=2 then clears on gnt1.
6. Reset mid-read: grant a port-0 read in the same cycle rst_n=0 is sampled → no rvalid0 next cycle; rdata0=0; starve_cnt=0.
